pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 122 ++++++++++++
 tb/tb_pipelined_adder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: each of STAGES register stages resolves WIDTH/STAGES bits.
// Optional macro PIPELINED_ADDER_SAT_EN clamps z to the signed range on overflow.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int NS    = (STAGES < 1) ? 1 : STAGES;
  localparam int SLICE = WIDTH / NS;
  localparam int LAST  = NS - 1;

  if (STAGES < 1 || (WIDTH % NS) != 0) begin : g_bad_cfg
    $fatal(1, "pipelined_adder: STAGES must be >= 1 and divide WIDTH");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipe moves as one unit, so the input is ready exactly when
  // the output slot is empty or being drained this cycle.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NS; k++) begin : stg
    // IW: operand bits still unconsumed on entry; XW: bits kept after this stage
    // (the last stage keeps only the operand MSBs for the overflow decision).
    localparam int IW = WIDTH - k * SLICE;
    localparam int XW = (k == LAST) ? 1 : IW - SLICE;
    localparam int SW = (k + 1) * SLICE;

    logic             in_v, in_sub, in_c;
    logic [IW-1:0]    in_x, in_y;
    logic [SLICE:0]   sum;
    logic [XW-1:0]    x_nxt, y_nxt;
    logic [SW-1:0]    s_nxt;

    logic             v_q, sub_q, c_q;
    logic [XW-1:0]    x_q, y_q;
    logic [SW-1:0]    s_q;

    if (k == 0) begin : g_head
      assign in_v   = in_valid;
      assign in_sub = sub;
      assign in_c   = cin ^ sub;
      assign in_x   = x;
      assign in_y   = y;
      assign s_nxt  = sum[SLICE-1:0];
    end else begin : g_body
      assign in_v   = stg[k-1].v_q;
      assign in_sub = stg[k-1].sub_q;
      assign in_c   = stg[k-1].c_q;
      assign in_x   = stg[k-1].x_q;
      assign in_y   = stg[k-1].y_q;
      assign s_nxt  = {sum[SLICE-1:0], stg[k-1].s_q};
    end

    if (k == LAST) begin : g_tail
      assign x_nxt = in_x[IW-1];
      assign y_nxt = in_y[IW-1];
    end else begin : g_mid
      assign x_nxt = in_x[IW-1:SLICE];
      assign y_nxt = in_y[IW-1:SLICE];
    end

    // y travels raw; the subtract inversion is applied to each slice as it is consumed.
    assign sum = {1'b0, in_x[SLICE-1:0]}
               + {1'b0, in_y[SLICE-1:0] ^ {SLICE{in_sub}}}
               + {{SLICE{1'b0}}, in_c};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        sub_q <= 1'b0;
        c_q   <= 1'b0;
        x_q   <= '0;
        y_q   <= '0;
        s_q   <= '0;
      end else if (advance) begin
        v_q   <= in_v;
        sub_q <= in_sub;
        c_q   <= sum[SLICE];
        x_q   <= x_nxt;
        y_q   <= y_nxt;
        s_q   <= s_nxt;
      end
    end
  end

  logic [WIDTH-1:0] sum_z;
  logic             x_msb, y_msb;

  assign sum_z     = stg[LAST].s_q;
  assign x_msb     = stg[LAST].x_q[0];
  assign y_msb     = stg[LAST].y_q[0] ^ stg[LAST].sub_q;
  assign out_valid = stg[LAST].v_q;
  assign cout      = stg[LAST].c_q;
  assign ovf       = (x_msb == y_msb) && (sum_z[WIDTH-1] != x_msb);

`ifdef PIPELINED_ADDER_SAT_EN
  // On overflow both effective operands share a sign, which is the sign of the true result.
  always_comb begin
    z = sum_z;
    if (ovf) z = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign z = sum_z;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector bench for pipelined_adder (WIDTH=8, STAGES=2) with a queue scoreboard
// and an independent output monitor.
module tb_pipelined_adder;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x, y;
  logic             cin, sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             cout, ovf;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [WIDTH+1:0] exp_q[$];   // {z, cout, ovf}
  int               acc_q[$];   // presentation cycle, -1 = latency not checked
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Picks the saturated expectation when the build enables clamping.
  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] zw, input logic [WIDTH-1:0] zs);
`ifdef PIPELINED_ADDER_SAT_EN
    return zs;
`else
    return zw;
`endif
  endfunction

  // ---------------- monitor ----------------
  logic             hold_armed = 1'b0;
  logic [WIDTH+1:0] held;

  always @(negedge clk) begin
    logic [WIDTH+1:0] e;
    int               a;
    if (!rst_n) begin
      hold_armed = 1'b0;
    end else if (out_valid) begin
      if (hold_armed) check("hold_stable", {z, cout, ovf}, held);
      if (out_ready) begin
        hold_armed = 1'b0;
        if (exp_q.size() == 0) begin
          check("spurious_output", {z, cout, ovf}, '1);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("result", {z, cout, ovf}, e);
          if (a >= 0) check("latency", cyc - a, STAGES);
        end
      end else begin
        hold_armed = 1'b1;
        held       = {z, cout, ovf};
      end
    end else begin
      hold_armed = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the slot just after a rising edge; returns in the same kind of slot.
  task automatic issue(input logic [7:0] xv, input logic [7:0] yv, input logic cv, input logic sv,
                       input logic [7:0] ez, input logic ec, input logic eo, input bit lat);
    int waited = 0;
    in_valid = 1'b1;
    x = xv; y = yv; cin = cv; sub = sv;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({ez, ec, eo});
        acc_q.push_back(lat ? cyc : -1);
        break;
      end
      waited++;
      if (waited > 20) begin
        check("accept_timeout", waited, 0);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 0);
    check("rst_cout_ovf", {cout, ovf}, 0);
    rst_n = 1'b1;
    check("in_ready_after_rst", in_ready, 1);

    // Headline cases: carry out, signed overflow, subtract borrow, subtract overflow.
    issue(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1);
    issue(8'h7F, 8'h01, 0, 0, pick(8'h80, 8'h7F), 0, 1, 1);
    issue(8'h05, 8'h07, 0, 1, 8'hFE, 0, 0, 1);
    issue(8'h80, 8'h01, 0, 1, pick(8'h7F, 8'h80), 1, 1, 1);
    repeat (4) tick();

    // Back-to-back stream of 16 hand-computed vectors.
    issue(8'h12, 8'h34, 0, 0, 8'h46, 0, 0, 1);
    issue(8'h12, 8'h34, 1, 0, 8'h47, 0, 0, 1);
    issue(8'h80, 8'h80, 0, 0, pick(8'h00, 8'h80), 1, 1, 1);
    issue(8'hFF, 8'hFF, 1, 0, 8'hFF, 1, 0, 1);
    issue(8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, 1);
    issue(8'h0F, 8'h00, 1, 0, 8'h10, 0, 0, 1);
    issue(8'h40, 8'h40, 0, 0, pick(8'h80, 8'h7F), 0, 1, 1);
    issue(8'h7F, 8'h7F, 1, 0, pick(8'hFF, 8'h7F), 0, 1, 1);
    issue(8'h00, 8'h00, 0, 1, 8'h00, 1, 0, 1);
    issue(8'h00, 8'h00, 1, 1, 8'hFF, 0, 0, 1);
    issue(8'h10, 8'h01, 0, 1, 8'h0F, 1, 0, 1);
    issue(8'h7F, 8'hFF, 0, 1, pick(8'h80, 8'h7F), 0, 1, 1);
    issue(8'h80, 8'h7F, 0, 1, pick(8'h01, 8'h80), 1, 1, 1);
    issue(8'h55, 8'hAA, 1, 1, pick(8'hAA, 8'h7F), 0, 1, 1);
    issue(8'hFF, 8'h01, 1, 1, 8'hFD, 1, 0, 1);
    issue(8'hA5, 8'h5A, 1, 0, 8'h00, 1, 0, 1);
    repeat (4) tick();

    // Back-pressure: stall the first result for three cycles while junk is offered.
    issue(8'h01, 8'h02, 0, 0, 8'h03, 0, 0, 0);
    issue(8'h10, 8'h20, 0, 0, 8'h30, 0, 0, 0);
    out_ready = 1'b0;
    check("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = 8'hEE; y = 8'hEE; cin = 1'b1; sub = 1'b0;
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    issue(8'h09, 8'h03, 0, 1, 8'h06, 1, 0, 0);
    issue(8'hF0, 8'h0F, 0, 0, 8'hFF, 0, 0, 0);
    repeat (5) tick();
    check("bp_drained", exp_q.size(), 0);

    // Mid-flight reset: one result stalled at the output, one in stage 0.
    issue(8'h11, 8'h11, 0, 0, 8'h22, 0, 0, 0);
    out_ready = 1'b0;
    issue(8'h33, 8'h33, 0, 0, 8'h66, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    out_ready = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_z", z, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (6) tick();

    // Post-reset sanity: the pipe still works.
    issue(8'h3C, 8'h03, 0, 0, 8'h3F, 0, 0, 1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    check("final_drain", exp_q.size(), 0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
